// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table controller:
// 2-bit predictor state encoding and the controller FSM states.
package bht_pkg;

  typedef logic [1:0] bht_state_t;

  localparam bht_state_t SNT = 2'b00;
  localparam bht_state_t WNT = 2'b01;
  localparam bht_state_t WT  = 2'b10;
  localparam bht_state_t ST  = 2'b11;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_t;

endpackage

// File: rtl/bht_next_state.sv
// Combinational predictor state transition: current state plus
// mispredicted flag gives the state to write back into the table.
module bht_next_state
  import bht_pkg::*;
(
  input  bht_state_t state,
  input  logic       mispredicted,
  output bht_state_t next_state
);

  always_comb begin
    next_state = state;
    case (state)
      SNT:     next_state = mispredicted ? WNT : SNT;
      WNT:     next_state = mispredicted ? ST  : SNT;
      ST:      next_state = mispredicted ? WT  : ST;
      WT:      next_state = mispredicted ? SNT : ST;
      default: next_state = state;
    endcase
  end

endmodule

// File: rtl/bht_controller.sv
// Branch history table controller: single-port predictor table shared by
// fetch lookups and execute updates, with an init walker and a 2-entry update queue.
module bht_controller
  import bht_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lookup_valid,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            lookup_ready,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [1:0]      pred_state,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [1:0]      upd_state,
  input  logic            upd_mispredicted,
  output logic            upd_ready,
  output logic            init_busy
);

  localparam int                 DEPTH    = 1 << INDEX_W;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    bht_state_t         state;
  } q_entry_t;

  ctrl_state_t        state_reg, state_next;
  logic [INDEX_W-1:0] init_idx_reg, init_idx_next;
  logic [1:0]         count_reg, count_next;
  logic               pred_valid_reg;
  bht_state_t         pred_state_reg;

  bht_state_t         table_mem [DEPTH];
  q_entry_t           q_cur [2];

  logic [INDEX_W-1:0] lookup_idx, upd_idx;
  bht_state_t         upd_next;
  q_entry_t           upd_entry;
  logic               do_read, do_pop, do_push, push_slot;
  logic               tbl_we;
  logic [INDEX_W-1:0] tbl_waddr;
  bht_state_t         tbl_wdata;
  logic [1:0]         hit;
  bht_state_t         rd_data;
  logic               pc_unused;

  assign lookup_idx = lookup_pc[INDEX_W+1:2];
  assign upd_idx    = upd_pc[INDEX_W+1:2];
  assign pc_unused  = ^{lookup_pc[PC_W-1:INDEX_W+2], lookup_pc[1:0],
                        upd_pc[PC_W-1:INDEX_W+2], upd_pc[1:0]};

  // Next state is resolved at accept time so the queue only holds final values.
  bht_next_state u_next_state (
    .state        (upd_state),
    .mispredicted (upd_mispredicted),
    .next_state   (upd_next)
  );

  assign upd_entry = '{index: upd_idx, state: upd_next};

  always_comb begin
    state_next    = state_reg;
    init_idx_next = init_idx_reg;
    init_busy     = 1'b0;
    lookup_ready  = 1'b0;
    upd_ready     = 1'b0;
    do_read       = 1'b0;
    do_pop        = 1'b0;
    tbl_we        = 1'b0;
    tbl_waddr     = init_idx_reg;
    tbl_wdata     = WNT;
    case (state_reg)
      INIT: begin
        init_busy     = 1'b1;
        tbl_we        = 1'b1;
        init_idx_next = init_idx_reg + 1'b1;
        if (init_idx_reg == LAST_IDX) state_next = RUN;
      end
      RUN: begin
        lookup_ready = (count_reg != 2'd2);
        upd_ready    = (count_reg != 2'd2);
        // A full queue always wins the port so lookups lose at most every other cycle.
        if (count_reg == 2'd2)      do_pop  = 1'b1;
        else if (lookup_valid)      do_read = 1'b1;
        else if (count_reg != 2'd0) do_pop  = 1'b1;
        if (do_pop) begin
          tbl_we    = 1'b1;
          tbl_waddr = q_cur[0].index;
          tbl_wdata = q_cur[0].state;
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign do_push    = upd_valid && upd_ready;
  assign push_slot  = do_pop ? 1'(count_reg - 2'd1) : count_reg[0];
  assign count_next = count_reg + {1'b0, do_push} - {1'b0, do_pop};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_queue
      q_entry_t entry_reg;
      q_entry_t shift_in;

      if (gi == 0) begin : g_head
        assign shift_in = q_cur[1];
      end else begin : g_tail
        assign shift_in = entry_reg;
      end

      always_ff @(posedge clk) begin
        if (do_push && push_slot == 1'(gi)) entry_reg <= upd_entry;
        else if (do_pop)                    entry_reg <= shift_in;
      end

      assign q_cur[gi] = entry_reg;
      // Bypass only considers entries queued at the start of this cycle.
      assign hit[gi]   = (count_reg > 2'(gi)) && (q_cur[gi].index == lookup_idx);
    end
  endgenerate

  assign rd_data = hit[1] ? q_cur[1].state :
                   hit[0] ? q_cur[0].state : table_mem[lookup_idx];

  always_ff @(posedge clk) begin
    if (tbl_we) table_mem[tbl_waddr] <= tbl_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= INIT;
      init_idx_reg   <= '0;
      count_reg      <= 2'd0;
      pred_valid_reg <= 1'b0;
      pred_state_reg <= SNT;
    end else begin
      state_reg      <= state_next;
      init_idx_reg   <= init_idx_next;
      count_reg      <= count_next;
      pred_valid_reg <= do_read;
      if (do_read) pred_state_reg <= rd_data;
    end
  end

  assign pred_valid = pred_valid_reg;
  assign pred_state = pred_state_reg;
  assign pred_taken = pred_state_reg[1];

endmodule

// File: doc/bht_controller.md
# bht_controller

Branch history table controller for the fetch/execute pipeline. Owns a 2^INDEX_W-entry array of 2-bit saturating predictor states behind a single access port, and shares that port between fetch-stage lookups and execute-stage updates. A reset-time walker initialises the table. A 2-entry update queue with lookup bypass keeps predictions coherent with pending updates.

## Interface
Parameters:
- INDEX_W, 6, table index width; the table has 2^INDEX_W entries
- PC_W, 32, program counter width; table index = pc[INDEX_W+1:2]

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- lookup_valid  in  1  fetch requests a prediction
- lookup_pc  in  PC_W  PC of the fetched branch
- lookup_ready  out  1  lookup accepted this cycle when lookup_valid and lookup_ready are both high
- pred_valid  out  1  prediction valid, one cycle after an accepted lookup
- pred_taken  out  1  predicted direction, equal to pred_state[1]
- pred_state  out  2  state read; carried down the pipe and returned on upd_state
- upd_valid  in  1  execute resolves a branch
- upd_pc  in  PC_W  PC of the resolved branch
- upd_state  in  2  state the prediction was made with
- upd_mispredicted  in  1  resolved direction differs from the prediction
- upd_ready  out  1  update accepted this cycle when upd_valid and upd_ready are both high
- init_busy  out  1  table initialisation in progress

## Operation
- State encoding (package): SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11. Taken means state[1]=1.
- Next-state function, where m is upd_mispredicted:
  - SNT: m → WNT; !m → SNT
  - WNT: m → ST; !m → SNT
  - ST: m → WT; !m → ST
  - WT: m → SNT; !m → ST
- Controller FSM has two states: INIT and RUN.
- INIT:
  - Entered on reset.
  - An index counter walks 0 to 2^INDEX_W-1, writing WNT to one entry per cycle.
  - init_busy=1, lookup_ready=0, upd_ready=0.
  - Leaves for RUN after the last write.
- RUN:
  - The array performs exactly one access per cycle: a read or a write, never both.
  - Accepted updates compute next_state from upd_state and upd_mispredicted at accept time. {index, next_state} is then pushed into a 2-entry FIFO.
  - upd_ready = (queue count < 2).
  - A push and a pop in the same cycle are legal; count is unchanged.
- Arbitration priority:
  1. Queue full (count==2): the head entry writes and pops. lookup_ready=0.
  2. Otherwise, if lookup_valid: the lookup reads. lookup_ready=1.
  3. Otherwise, if queue non-empty: the head writes and pops.
- Bypass:
  - The read result is replaced by the youngest queued entry whose index matches, using queue contents as they stand at the start of the cycle.
  - An update accepted in the same cycle as a lookup is not visible to that lookup.
- An entry that is written supersedes the array value. Later lookups return the written state.

## Timing
- Reset values: pred_valid=0, pred_taken=0, pred_state=2'b00, lookup_ready=0, upd_ready=0, init_busy=1, queue count=0, FSM=INIT.
- init_busy stays high for exactly 2^INDEX_W cycles after rst_n rises (64 cycles at default). It falls on the edge after the write to the last index.
- Lookup accepted in cycle N → pred_valid=1 in N+1, with registered pred_state and pred_taken. Otherwise pred_valid=0.
- Update accepted in cycle N → earliest array write in N+1. That write is visible to a lookup in N+1 through the bypass, and through the array from N+2 on.
- Simultaneous full queue and lookup: the lookup stalls exactly one cycle, and that cycle the queue drains to count 1.
- Back-to-back updates with continuous lookups:
  - The queue fills after two accepted updates.
  - After that, every other cycle is a forced write.
  - Lookup throughput is never less than 50%.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately (asynchronous).
  - The queue is flushed and pending updates are lost.
  - A full INIT walk repeats.

## Structure
- Shared package bht_pkg holds the SNT/WNT/WT/ST localparams, the bht_state_t 2-bit typedef, and the FSM state typedef {INIT, RUN}.
- One sub-module, bht_next_state: purely combinational (state, mispredicted) → next_state per the rules above. It is instantiated once at the update accept point.
- The table is a flopped array with an asynchronous-reset-free data path; only control flops take rst_n.

## Test plan
- Reset release, idle inputs → init_busy high for 64 cycles. Then lookup pc=0x40 gives pred_valid one cycle later with pred_state=WNT and pred_taken=0.
- Update pc=0x40, upd_state=WNT, mispredicted=1, then lookup pc=0x40 two cycles later → pred_state=ST, pred_taken=1.
- Update pc=0x80, upd_state=ST, mispredicted=1, accepted in the same cycle as continuous lookups of pc=0x80 → the first lookup returns ST, and the lookup in the next cycle returns WT via the bypass.
- Four updates on consecutive cycles while lookup_valid is held high → upd_ready drops after two entries. lookup_ready pulses low on forced-write cycles, and all four indices end with the correct states.
- Two queued updates to the same index (WT then mispredicted → SNT, then SNT correct → SNT) → a lookup returns the youngest value, SNT.
- Assert rst_n low with two updates queued → outputs go to reset values in the same cycle. After release, lookups of the updated indices return WNT following a fresh 64-cycle INIT.
